// File: rtl/comm_pkg.sv
// Shared types and widths for the link transmit scheduler.
package comm_pkg;

    localparam int BALL_Y_W = 9;
    localparam int VEL_W    = 4;
    localparam int SCORE_W  = 5;

    typedef enum logic [1:0] {
        MSG_BALL,
        MSG_MISS,
        MSG_NEW_GAME,
        MSG_NEW_GAME_ACK
    } msg_type_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK
    } txsched_state_t;

    typedef struct packed {
        logic [BALL_Y_W-1:0] y;
        logic [VEL_W-1:0]    vel_x;
        logic [VEL_W-1:0]    vel_y;
    } ball_payload_t;

    typedef struct packed {
        logic [SCORE_W-1:0] my_score;
        logic [SCORE_W-1:0] your_score;
        logic               serve;
    } miss_payload_t;

endpackage

// File: rtl/comm_retry_timer.sv
// Down-counter used to time out the peer's new_game acknowledgement.
// Saturates at zero, so expired stays high until the next load.
module comm_retry_timer #(
    parameter int unsigned ACK_TIMEOUT = 1_000_000
) (
    input  logic clock,
    input  logic reset_L,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Load wins over counting; hold at zero once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = CW'(ACK_TIMEOUT);
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/comm_tx_scheduler.sv
// Latches outbound message requests, sends them by fixed priority over the
// sender handshake, and retries new_game until the peer acknowledges it.
module comm_tx_scheduler
    import comm_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1_000_000,
    parameter int unsigned MAX_RETRY   = 8
) (
    input  logic                clock,
    input  logic                reset_L,
    input  logic                ball_req,
    input  logic [BALL_Y_W-1:0] ball_y_in,
    input  logic [VEL_W-1:0]    vel_x_in,
    input  logic [VEL_W-1:0]    vel_y_in,
    input  logic                miss_req,
    input  logic [SCORE_W-1:0]  my_score_in,
    input  logic [SCORE_W-1:0]  your_score_in,
    input  logic                you_should_serve_in,
    input  logic                new_game_req,
    input  logic                you_serve_first_in,
    input  logic                ack_req,
    input  logic                new_game_ack_rx,
    output logic                send_new_message,
    input  logic                message_sent,
    output logic                ball_message_tx,
    output logic                miss_message_tx,
    output logic                new_game_message_tx,
    output logic                new_game_ack_message_tx,
    output logic [BALL_Y_W-1:0] ball_y_tx,
    output logic [VEL_W-1:0]    velocity_x_tx,
    output logic [VEL_W-1:0]    velocity_y_tx,
    output logic [SCORE_W-1:0]  my_score_tx,
    output logic [SCORE_W-1:0]  your_score_tx,
    output logic                you_should_serve_tx,
    output logic                you_serve_first_tx,
    output logic                link_up,
    output logic                link_error
);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    txsched_state_t state_q, state_d;
    logic           send_q, send_d;
    logic [3:0]     type_q, type_d;
    ball_payload_t  ball_tx_q, ball_tx_d, ball_slot_q, ball_slot_d;
    miss_payload_t  miss_tx_q, miss_tx_d, miss_slot_q, miss_slot_d;
    logic           first_tx_q, first_tx_d, ng_first_q, ng_first_d;
    logic           ball_pend_q, ball_pend_d, miss_pend_q, miss_pend_d;
    logic           ng_pend_q, ng_pend_d, ack_pend_q, ack_pend_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           await_q, await_d;
    logic           link_up_q, link_up_d, link_error_q, link_error_d;
    logic           tmr_load, tmr_expired, take;
    msg_type_t      take_type;

    // await_q marks an outstanding new_game; the timer keeps running while an
    // ack is squeezed in between, so expiry is not pushed out by our own sends.
    comm_retry_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset_L (reset_L),
        .load    (tmr_load),
        .en      (await_q),
        .expired (tmr_expired)
    );

    // Next-state: FSM and slot consumption first, then request capture so a
    // pulse landing on the consume cycle re-arms its slot with the new payload.
    always_comb begin
        state_d      = state_q;
        send_d       = send_q;
        type_d       = type_q;
        ball_tx_d    = ball_tx_q;
        miss_tx_d    = miss_tx_q;
        first_tx_d   = first_tx_q;
        ball_pend_d  = ball_pend_q;
        ball_slot_d  = ball_slot_q;
        miss_pend_d  = miss_pend_q;
        miss_slot_d  = miss_slot_q;
        ng_pend_d    = ng_pend_q;
        ng_first_d   = ng_first_q;
        ack_pend_d   = ack_pend_q;
        retry_d      = retry_q;
        await_d      = await_q;
        link_up_d    = link_up_q;
        link_error_d = link_error_q;
        tmr_load     = 1'b0;
        take         = 1'b0;
        take_type    = MSG_BALL;

        case (state_q)
            IDLE: begin
                take = 1'b1;
                if (ack_pend_q)       take_type = MSG_NEW_GAME_ACK;
                else if (ng_pend_q)   take_type = MSG_NEW_GAME;
                else if (miss_pend_q) take_type = MSG_MISS;
                else if (ball_pend_q) take_type = MSG_BALL;
                else                  take      = 1'b0;
            end
            SEND: begin
                if (message_sent) begin
                    send_d     = 1'b0;
                    type_d     = '0;
                    ball_tx_d  = '0;
                    miss_tx_d  = '0;
                    first_tx_d = 1'b0;
                    if (type_q[MSG_NEW_GAME]) begin
                        tmr_load = 1'b1;
                        await_d  = 1'b1;
                        state_d  = WAIT_ACK;
                    end else begin
                        state_d  = await_q ? WAIT_ACK : IDLE;
                    end
                end
            end
            WAIT_ACK: begin
                if (new_game_ack_rx) begin
                    link_up_d = 1'b1;
                    retry_d   = '0;
                    await_d   = 1'b0;
                    state_d   = IDLE;
                end else if (ack_pend_q) begin
                    take      = 1'b1;
                    take_type = MSG_NEW_GAME_ACK;
                end else if (tmr_expired) begin
                    await_d = 1'b0;
                    state_d = IDLE;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        ng_pend_d = 1'b1;
                        retry_d   = retry_q + 1'b1;
                    end else begin
                        link_error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d    = SEND;
            send_d     = 1'b1;
            type_d     = '0;
            type_d[take_type] = 1'b1;
            ball_tx_d  = '0;
            miss_tx_d  = '0;
            first_tx_d = 1'b0;
            case (take_type)
                MSG_BALL:     begin ball_tx_d  = ball_slot_q; ball_pend_d = 1'b0; end
                MSG_MISS:     begin miss_tx_d  = miss_slot_q; miss_pend_d = 1'b0; end
                MSG_NEW_GAME: begin first_tx_d = ng_first_q;  ng_pend_d   = 1'b0; end
                default:      ack_pend_d = 1'b0;
            endcase
        end

        if (ball_req) begin
            ball_pend_d = 1'b1;
            ball_slot_d = '{y: ball_y_in, vel_x: vel_x_in, vel_y: vel_y_in};
        end
        if (miss_req) begin
            miss_pend_d = 1'b1;
            miss_slot_d = '{my_score: my_score_in, your_score: your_score_in,
                            serve: you_should_serve_in};
        end
        if (ack_req)
            ack_pend_d = 1'b1;
        // A fresh new_game abandons any outstanding one and restarts the retries.
        if (new_game_req) begin
            ng_pend_d  = 1'b1;
            ng_first_d = you_serve_first_in;
            link_up_d  = 1'b0;
            retry_d    = '0;
            await_d    = 1'b0;
            if (state_d == WAIT_ACK) state_d = IDLE;
        end
    end

    // State, slot and output registers.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            send_q       <= 1'b0;
            type_q       <= '0;
            ball_tx_q    <= '0;
            miss_tx_q    <= '0;
            first_tx_q   <= 1'b0;
            ball_pend_q  <= 1'b0;
            ball_slot_q  <= '0;
            miss_pend_q  <= 1'b0;
            miss_slot_q  <= '0;
            ng_pend_q    <= 1'b0;
            ng_first_q   <= 1'b0;
            ack_pend_q   <= 1'b0;
            retry_q      <= '0;
            await_q      <= 1'b0;
            link_up_q    <= 1'b0;
            link_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            send_q       <= send_d;
            type_q       <= type_d;
            ball_tx_q    <= ball_tx_d;
            miss_tx_q    <= miss_tx_d;
            first_tx_q   <= first_tx_d;
            ball_pend_q  <= ball_pend_d;
            ball_slot_q  <= ball_slot_d;
            miss_pend_q  <= miss_pend_d;
            miss_slot_q  <= miss_slot_d;
            ng_pend_q    <= ng_pend_d;
            ng_first_q   <= ng_first_d;
            ack_pend_q   <= ack_pend_d;
            retry_q      <= retry_d;
            await_q      <= await_d;
            link_up_q    <= link_up_d;
            link_error_q <= link_error_d;
        end
    end

    assign send_new_message        = send_q;
    assign ball_message_tx         = type_q[MSG_BALL];
    assign miss_message_tx         = type_q[MSG_MISS];
    assign new_game_message_tx     = type_q[MSG_NEW_GAME];
    assign new_game_ack_message_tx = type_q[MSG_NEW_GAME_ACK];
    assign ball_y_tx               = ball_tx_q.y;
    assign velocity_x_tx           = ball_tx_q.vel_x;
    assign velocity_y_tx           = ball_tx_q.vel_y;
    assign my_score_tx             = miss_tx_q.my_score;
    assign your_score_tx           = miss_tx_q.your_score;
    assign you_should_serve_tx     = miss_tx_q.serve;
    assign you_serve_first_tx      = first_tx_q;
    assign link_up                 = link_up_q;
    assign link_error              = link_error_q;

endmodule
